mul_div_unit: RTL and testbench

Iterative 64-bit multiply/divide unit in the execute stage, directly downstream of the register file. It consumes the two register read buses and computes MUL, UMULH, UDIV or SDIV over multiple cycles. It presents the result, destination register and a one-cycle write strobe that drive the register file's write-data, write-address and write-enable inputs.

---
 rtl/mul_div_unit_pkg.sv | 22 ++
 rtl/mul_div_unit_if.sv | 29 ++
 rtl/mul_div_unit.sv | 129 ++++++++++++
 tb/tb_mul_div_unit.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared constants, op codes and FSM states for mul_div_unit
// Contents: XLEN / REG_W / CNT_W widths, op_e request encodings, state_e FSM encodings.
package mul_div_unit_pkg;

  localparam int XLEN  = 64;
  localparam int REG_W = 5;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULH = 2'b01,
    OP_UDIV  = 2'b10,
    OP_SDIV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/response bundle between register file and mul_div_unit
// Request : start, op[1:0], busRN/busRM operands, Rd_in destination.
// Response: busy, done, we (write strobe), Rd, result.
// Modports: master drives requests (register file side), slave is the unit.
interface mul_div_unit_if;
  import mul_div_unit_pkg::*;

  logic             start;
  logic [1:0]       op;
  logic [XLEN-1:0]  busRN;
  logic [XLEN-1:0]  busRM;
  logic [REG_W-1:0] Rd_in;
  logic             busy;
  logic             done;
  logic             we;
  logic [REG_W-1:0] Rd;
  logic [XLEN-1:0]  result;

  modport master (
    output start, op, busRN, busRM, Rd_in,
    input  busy, done, we, Rd, result
  );

  modport slave (
    input  start, op, busRN, busRM, Rd_in,
    output busy, done, we, Rd, result
  );

endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 64-bit MUL/UMULH/UDIV/SDIV unit, one radix-2 step per cycle
// Ports: clk, rst (async, active-high), bus (mul_div_unit_if.slave).
// A request accepted in IDLE runs 64 CALC steps, then raises done/we for one
// cycle with result and Rd stable. Divide by zero skips CALC and returns 0.
module mul_div_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  bus
);
  import mul_div_unit_pkg::*;

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  // Multiply: {product_hi, multiplier} shifting right.
  // Divide  : {remainder, quotient} shifting left.
  logic [2*XLEN-1:0]  work, work_nxt;
  logic [XLEN-1:0]    opnd;       // multiplicand or divisor magnitude
  op_e                op_q;
  logic               neg_q;      // SDIV operand signs differ
  logic [REG_W-1:0]   rd_q;
  logic [XLEN-1:0]    result_q;
  logic [XLEN-1:0]    result_sel;

  logic               accept;
  logic               div_zero;
  logic               a_neg, b_neg;
  logic [XLEN-1:0]    abs_a, abs_b;
  logic [XLEN-1:0]    addend;
  logic [XLEN:0]      sum, rem_sh, diff;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return (~v) + XLEN'(1);
  endfunction

  assign accept   = (state == ST_IDLE) && bus.start;
  assign div_zero = bus.op[1] && (bus.busRM == '0);
  assign a_neg    = (bus.op == OP_SDIV) && bus.busRN[XLEN-1];
  assign b_neg    = (bus.op == OP_SDIV) && bus.busRM[XLEN-1];
  // |INT_MIN| stays 0x8000.. which is the correct unsigned magnitude.
  assign abs_a    = a_neg ? negate(bus.busRN) : bus.busRN;
  assign abs_b    = b_neg ? negate(bus.busRM) : bus.busRM;

  // One iteration of either algorithm.
  always_comb begin
    addend = work[0] ? opnd : '0;
    sum    = {1'b0, work[2*XLEN-1:XLEN]} + {1'b0, addend};
    rem_sh = work[2*XLEN-1:XLEN-1];
    diff   = rem_sh - {1'b0, opnd};
    if (op_q[1]) begin
      if (diff[XLEN]) work_nxt = {rem_sh[XLEN-1:0], work[XLEN-2:0], 1'b0};
      else            work_nxt = {diff[XLEN-1:0],   work[XLEN-2:0], 1'b1};
    end else begin
      work_nxt = {sum, work[XLEN-1:1]};
    end
  end

  always_comb begin
    result_sel = work_nxt[XLEN-1:0];
    case (op_q)
      OP_UMULH: result_sel = work_nxt[2*XLEN-1:XLEN];
      OP_SDIV:  result_sel = neg_q ? negate(work_nxt[XLEN-1:0]) : work_nxt[XLEN-1:0];
      default:  result_sel = work_nxt[XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    bus.we    = 1'b0;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = div_zero ? ST_DONE : ST_CALC;
      ST_CALC: begin
        bus.busy = 1'b1;
        if (&cnt) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        bus.we    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      work     <= '0;
      opnd     <= '0;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= op_e'(bus.op);
        rd_q  <= bus.Rd_in;
        cnt   <= '0;
        neg_q <= a_neg ^ b_neg;
        if (bus.op[1]) begin
          work <= {{XLEN{1'b0}}, abs_a};
          opnd <= abs_b;
        end else begin
          work <= {{XLEN{1'b0}}, bus.busRM};
          opnd <= bus.busRN;
        end
        if (div_zero) result_q <= '0;
      end else if (state == ST_CALC) begin
        work <= work_nxt;
        cnt  <= cnt + CNT_W'(1);
        if (&cnt) result_q <= result_sel;
      end
    end
  end

  assign bus.Rd     = rd_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  mul_div_unit_if bus ();

  mul_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done) done_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and wait for its done pulse; latency counted in
  // negedges after the accepting edge (64 normally, 0 for divide by zero).
  task automatic do_op(input string tag, input logic [1:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd,
                       input logic [63:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.busRN = a; bus.busRM = b; bus.Rd_in = rd;
    @(negedge clk);
    bus.start = 1'b0; bus.busRN = '1; bus.busRM = '1; bus.Rd_in = 5'd31;
    lat = 0;
    while (!bus.done && lat < 200) begin
      check({tag, "_busy"}, 64'(bus.busy), 64'd1);
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, bus.result, exp);
    check({tag, "_rd"}, 64'(bus.Rd), 64'(rd));
    check({tag, "_we"}, 64'(bus.we), 64'd1);
    @(negedge clk);
    check({tag, "_done_off"}, 64'(bus.done), 64'd0);
    check({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int d0;
    bus.start = 1'b0; bus.op = 2'b00; bus.busRN = '0; bus.busRM = '0; bus.Rd_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",   64'(bus.busy), 64'd0);
    check("rst_done",   64'(bus.done), 64'd0);
    check("rst_we",     64'(bus.we),   64'd0);
    check("rst_rd",     64'(bus.Rd),   64'd0);
    check("rst_result", bus.result,    64'd0);
    rst = 1'b0;

    do_op("mul7x6",  2'b00, 64'd7, 64'd6, 5'd5, 64'd42, 64);
    do_op("umulh",   2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, 64'd1, 64);
    do_op("mulmax",  2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64);
    do_op("udiv",    2'b10, 64'd100, 64'd7, 5'd3, 64'd14, 64);
    do_op("sdivneg", 2'b11, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd4, 64'hFFFF_FFFF_FFFF_FFF2, 64);
    do_op("sdivmin", 2'b11, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6,
          64'h8000_0000_0000_0000, 64);
    do_op("udiv0",   2'b10, 64'd5, 64'd0, 5'd7, 64'd0, 0);
    do_op("mulz",    2'b00, 64'd3, 64'd5, 5'd8, 64'd15, 64);
    do_op("sdiv0",   2'b11, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd9, 64'd0, 0);

    // Start pulsed mid-operation must be ignored.
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.busRN = 64'd7; bus.busRM = 64'd6; bus.Rd_in = 5'd10;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.busRN = 64'd9; bus.busRM = 64'd0; bus.Rd_in = 5'd11;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (54) @(negedge clk);
    check("ign_done", 64'(bus.done), 64'd1);
    check("ign_res",  bus.result, 64'd42);
    check("ign_rd",   64'(bus.Rd), 64'd10);
    repeat (80) @(negedge clk);
    check("ign_pulses", 64'(done_cnt - d0), 64'd1);

    // Reset in the middle of a multiply.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.busRN = 64'd11; bus.busRM = 64'd13; bus.Rd_in = 5'd12;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (29) @(negedge clk);
    check("mid_busy_pre", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_busy",   64'(bus.busy), 64'd0);
    check("mid_done",   64'(bus.done), 64'd0);
    check("mid_we",     64'(bus.we),   64'd0);
    check("mid_result", bus.result,    64'd0);
    check("mid_rd",     64'(bus.Rd),   64'd0);
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check("mid_no_done", 64'(done_cnt - d0), 64'd0);

    // Reset held over a start edge: nothing accepted.
    bus.start = 1'b1; bus.op = 2'b10; bus.busRN = 64'd1; bus.busRM = 64'd0; rst = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; rst = 1'b0;
    #1;
    check("rststart_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("rststart_done", 64'(bus.done), 64'd0);

    do_op("mul3x3", 2'b00, 64'd3, 64'd3, 5'd13, 64'd9, 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
